// File: rtl/dispatch8_rr_if.sv
// rtl/dispatch8_rr_if.sv - upstream stream, channel mask and 8-way demux control bundle for dispatch8_rr
interface dispatch8_rr_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [7:0]       chan_en;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       sel;
  logic             busy;

  modport master (
    input  in_valid, in_data, chan_en, out_ready,
    output in_ready, out_valid, out_data, sel, busy
  );

  modport slave (
    output in_valid, in_data, chan_en, out_ready,
    input  in_ready, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/dispatch8_rr.sv
// rtl/dispatch8_rr.sv - round-robin single-entry dispatcher driving an 8-way demux select
// Optional transfer counter port `dispatched` when DISPATCH8_STATS_EN is defined.
module dispatch8_rr #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  dispatch8_rr_if.master bus
`ifdef DISPATCH8_STATS_EN
  ,
  output logic [15:0]   dispatched
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       sel_q;
  logic [2:0]       tgt;
  logic [WIDTH-1:0] data_q;
  logic             found;
  logic             any_en;
  logic             in_rdy;
  logic             accept;
  logic             xfer;

  // First enabled channel at or after ptr, wrapping through index 7 back to 0.
  always_comb begin
    tgt   = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && bus.chan_en[ptr + 3'(k)]) begin
        tgt   = ptr + 3'(k);
        found = 1'b1;
      end
    end
  end

  assign any_en = |bus.chan_en;
  assign xfer   = (state == FULL) && bus.out_ready[sel_q];
  assign in_rdy = any_en && ((state == EMPTY) || bus.out_ready[sel_q]);
  assign accept = bus.in_valid && in_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (xfer && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Held word and target only change on accept, so they stay put until transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      sel_q  <= 3'd0;
      ptr    <= 3'd0;
    end else if (accept) begin
      data_q <= bus.in_data;
      sel_q  <= tgt;
      ptr    <= tgt + 3'd1;
    end
  end

`ifdef DISPATCH8_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dispatched <= 16'd0;
    end else if (xfer) begin
      dispatched <= dispatched + 16'd1;
    end
  end
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state == FULL) ? (8'b1 << sel_q) : 8'b0;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state == FULL);

endmodule

// File: tb/tb_dispatch8_rr.sv
// tb/tb_dispatch8_rr.sv - self-checking bench for dispatch8_rr with a behavioural reference model
module tb_dispatch8_rr;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset;

  dispatch8_rr_if #(.WIDTH(WIDTH)) bus ();
`ifdef DISPATCH8_STATS_EN
  logic [15:0] dispatched;
`endif

  dispatch8_rr #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef DISPATCH8_STATS_EN
    ,
    .dispatched (dispatched)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit               m_full;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_ptr;
  int               m_cnt;

  function automatic int pick(input int p, input logic [7:0] en);
    for (int k = 0; k < 8; k++) begin
      if (en[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  task automatic set_in(input bit v, input logic [WIDTH-1:0] d, input logic [7:0] en, input logic [7:0] rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.chan_en   = en;
    bus.out_ready = rdy;
  endtask

  task automatic tick();
    bit acc;
    bit xfer;
    int tgt;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      xfer = m_full && bus.out_ready[m_sel];
      acc  = bus.in_valid && (bus.chan_en != 8'h00) && (!m_full || bus.out_ready[m_sel]);
      tgt  = pick(m_ptr, bus.chan_en);
      if (xfer) m_cnt = (m_cnt + 1) % 65536;
      if (acc) begin
        m_data = bus.in_data;
        m_sel  = tgt;
        m_ptr  = (tgt + 1) % 8;
        m_full = 1'b1;
      end else if (xfer) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, 8'h00, 8'h00);
    reset = 1'b1;
    #3;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, '0, 8'h00, 8'h00);
    model_reset();
    @(negedge clk);
    checks++; if (bus.out_valid !== 8'h00) begin failures++; $display("FAIL reset_out_valid got=%h exp=00", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    checks++; if (bus.out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 16'(i), 8'hFF, 8'hFF);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rr_in_ready word=%0d got=%b exp=1", i, bus.in_ready); end
      if (i > 1) begin
        checks++; if (bus.out_valid !== 8'(1 << ((i - 2) % 8))) begin failures++; $display("FAIL rr_out_valid word=%0d got=%h exp=%h", i - 1, bus.out_valid, 8'(1 << ((i - 2) % 8))); end
        checks++; if (bus.out_data !== 16'(i - 1)) begin failures++; $display("FAIL rr_out_data word=%0d got=%h exp=%h", i - 1, bus.out_data, 16'(i - 1)); end
      end
      tick();
    end
    set_in(1'b0, '0, 8'hFF, 8'hFF);
    @(negedge clk);
    checks++; if (bus.out_valid !== 8'h02) begin failures++; $display("FAIL rr_last_valid got=%h exp=02", bus.out_valid); end
    checks++; if (bus.out_data !== 16'd10) begin failures++; $display("FAIL rr_last_data got=%h exp=000a", bus.out_data); end
    tick();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_drain_busy got=%b exp=0", bus.busy); end
    tick();
  endtask

  task automatic test_mask();
    logic [7:0] exp_v [4];
    exp_v[0] = 8'h01; exp_v[1] = 8'h04; exp_v[2] = 8'h01; exp_v[3] = 8'h04;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(i < 4, 16'(16'hA0 + i), 8'h05, 8'hFF);
      @(negedge clk);
      if (i > 0) begin
        checks++; if (bus.out_valid !== exp_v[i - 1]) begin failures++; $display("FAIL mask_out_valid word=%0d got=%h exp=%h", i - 1, bus.out_valid, exp_v[i - 1]); end
      end
      tick();
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'(16'h30 + i), 8'hFF, 8'hFF);
      tick();
    end
    held = 16'h33;
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, 16'h0044, 8'hFF, 8'hF7);
      @(negedge clk);
      checks++; if (bus.out_valid !== 8'h08) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%h exp=08", c, bus.out_valid); end
      checks++; if (bus.out_data !== held) begin failures++; $display("FAIL bp_out_data cyc=%0d got=%h exp=%h", c, bus.out_data, held); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      tick();
    end
    set_in(1'b1, 16'h0044, 8'hFF, 8'h08);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    set_in(1'b0, '0, 8'hFF, 8'h00);
    @(negedge clk);
    checks++; if (bus.out_valid !== 8'h10) begin failures++; $display("FAIL bp_pass_valid got=%h exp=10", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0044) begin failures++; $display("FAIL bp_pass_data got=%h exp=0044", bus.out_data); end
    tick();
  endtask

  task automatic test_no_enable();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 16'h0077, 8'h00, 8'hFF);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL noen_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 8'h00) begin failures++; $display("FAIL noen_out_valid cyc=%0d got=%h exp=00", c, bus.out_valid); end
      tick();
    end
    set_in(1'b1, 16'h0077, 8'h80, 8'hFF);
    tick();
    set_in(1'b1, 16'h0078, 8'h80, 8'hFF);
    @(negedge clk);
    checks++; if (bus.out_valid !== 8'h80) begin failures++; $display("FAIL noen_first_valid got=%h exp=80", bus.out_valid); end
    tick();
    set_in(1'b0, '0, 8'h80, 8'h00);
    @(negedge clk);
    checks++; if (bus.out_valid !== 8'h80) begin failures++; $display("FAIL noen_second_valid got=%h exp=80", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0078) begin failures++; $display("FAIL noen_second_data got=%h exp=0078", bus.out_data); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 16'(16'h50 + i), 8'hFF, 8'hFF);
      tick();
    end
    set_in(1'b0, '0, 8'hFF, 8'h00);
    @(negedge clk);
    checks++; if (bus.out_valid !== 8'h20) begin failures++; $display("FAIL ar_held_valid got=%h exp=20", bus.out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 8'h00) begin failures++; $display("FAIL ar_out_valid got=%h exp=00", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", bus.busy); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(1'b1, 16'h0099, 8'hFF, 8'hFF);
    tick();
    set_in(1'b0, '0, 8'hFF, 8'h00);
    @(negedge clk);
    checks++; if (bus.out_valid !== 8'h01) begin failures++; $display("FAIL ar_first_valid got=%h exp=01", bus.out_valid); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ev;
    logic       er;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      set_in($urandom_range(0, 3) != 0, 16'($urandom),
             ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
             ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom));
      @(negedge clk);
      ev = m_full ? 8'(1 << m_sel) : 8'h00;
      er = (bus.chan_en != 8'h00) && (!m_full || bus.out_ready[m_sel]);
      checks++; if (bus.out_valid !== ev) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=%h exp=%h", c, bus.out_valid, ev); end
      checks++; if (bus.in_ready !== er) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, er); end
      checks++; if (bus.out_data !== m_data) begin failures++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", c, bus.out_data, m_data); end
      checks++; if (bus.sel !== 3'(m_sel)) begin failures++; $display("FAIL rand_sel cyc=%0d got=%0d exp=%0d", c, bus.sel, m_sel); end
      checks++; if (bus.busy !== m_full) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, bus.busy, m_full); end
`ifdef DISPATCH8_STATS_EN
      checks++; if (dispatched !== 16'(m_cnt)) begin failures++; $display("FAIL rand_dispatched cyc=%0d got=%0d exp=%0d", c, dispatched, m_cnt); end
`endif
      tick();
    end
  endtask

`ifdef DISPATCH8_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      set_in(1'b1, 16'(i), 8'hFF, 8'hFF);
      tick();
    end
    set_in(1'b0, '0, 8'hFF, 8'hFF);
    tick();
    @(negedge clk);
    checks++; if (dispatched !== 16'd300) begin failures++; $display("FAIL stats_300 got=%0d exp=300", dispatched); end
    do_reset();
    set_in(1'b1, 16'h1234, 8'hFF, 8'hFF);
    repeat (65536) @(posedge clk);
    #1;
    set_in(1'b0, '0, 8'hFF, 8'hFF);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (dispatched !== 16'd0) begin failures++; $display("FAIL stats_wrap got=%0d exp=0", dispatched); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL stats_wrap_busy got=%b exp=0", bus.busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_mask();
    test_backpressure();
    test_no_enable();
    test_async_reset();
    test_random();
`ifdef DISPATCH8_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch8_rr.md
# dispatch8_rr

- Round-robin dispatcher that sequences the 8-way demultiplexing path.
- Accepts a stream of words on one valid/ready input.
- Holds each word in a single-entry register and steers it to exactly one of 8 destination channels, rotating through the enabled channels in index order.
- Drives the 3-bit channel select and the one-hot valid vector of the 8-way demux fabric; it is the sole owner of that select.

## Interface

Parameters:
- WIDTH, 16, data word width in bits

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word available
- in_ready  output  1  dispatcher accepts the word this cycle
- in_data  input  WIDTH  upstream word
- chan_en  input  8  per-channel enable mask; bit i = channel i eligible
- out_valid  output  8  one-hot; bit sel asserted while a word is held, else all zero
- out_ready  input  8  per-channel downstream ready
- out_data  output  WIDTH  held word, shared by all channels
- sel  output  3  target channel of the held word
- busy  output  1  high while a word is held (state FULL)

## Operation

- State: FSM {EMPTY, FULL}, round-robin pointer `ptr[2:0]`, hold register `out_data`, target register `sel`.
- Reset values, applied immediately on reset assertion:
  - state = EMPTY
  - ptr = 0, sel = 0
  - out_data = 0, out_valid = 0
  - busy = 0
- Target selection: tgt = first index j scanning ptr, ptr+1, …, ptr+7 (mod 8) with chan_en[j]=1. The scan is combinational on the current chan_en.
- Combinational outputs:
  - in_ready = (chan_en != 0) && (state==EMPTY || out_ready[sel]).
  - out_valid = (state==FULL) ? (8'b1 << sel) : 8'b0.
- Accept: in_valid && in_ready. On accept:
  - out_data <= in_data
  - sel <= tgt
  - ptr <= tgt+1 (mod 8, 3-bit wrap 7→0)
  - state <= FULL
- Transfer: state==FULL && out_ready[sel].
  - Transfer without accept: state <= EMPTY.
  - Transfer and accept in the same cycle: state stays FULL with the new word and target (pass-through, 1 word/cycle throughput).
- EMPTY transitions:
  - Accept → FULL.
  - No accept → stay EMPTY.
- FULL transitions:
  - Transfer without accept → EMPTY.
  - Transfer with accept → FULL.
  - No transfer → hold.
- Held word is sticky: out_data, sel and out_valid are stable until transfer. A chan_en change while FULL does not retarget the held word, even if its channel is disabled. chan_en affects only the next selection.
- chan_en == 0: in_ready = 0, no accept. A held word still completes.
- out_ready bits for channels other than sel are ignored.

## Timing

- Latency: a word accepted at edge N appears on out_valid/out_data immediately after edge N (1 cycle input-to-output).
- Throughput: 1 word/cycle while the target channels are ready and chan_en != 0.
- Handshakes:
  - in_ready may depend combinationally on out_ready[sel] and chan_en.
  - out_valid depends only on registers; it never depends combinationally on in_valid.
- Reset mid-operation:
  - A held word is discarded; out_valid drops asynchronously.
  - The first accept after reset release targets the lowest enabled channel.

## Configuration

- DISPATCH8_STATS_EN defined:
  - Adds output port `dispatched` (16 bits, reset 0).
  - Increments by 1 on every transfer, wrapping 65535→0.
  - A simultaneous accept does not affect the count.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan

- chan_en=8'hFF, out_ready=8'hFF; stream words 1..10 back-to-back:
  - Words go to channels 0,1,…,7,0,1.
  - in_ready stays 1.
  - Each word appears on out_valid one cycle after its accept.
- chan_en=8'h05, all ready, push 4 words:
  - Targets are 0,2,0,2.
  - out_valid is 8'h01, 8'h04, 8'h01, 8'h04.
- Word targeting channel 3, out_ready[3]=0 for 5 cycles:
  - out_valid=8'h08 and out_data stable; in_ready=0.
  - Raise out_ready[3] together with in_valid: transfer and accept in the same cycle; the next word targets channel 4.
- chan_en=0 with in_valid=1 for 4 cycles:
  - in_ready=0 and out_valid=0.
  - Set chan_en=8'h80: the word is accepted and targets channel 7; the following word targets 7 again.
- Assert reset asynchronously mid-cycle while FULL targeting channel 5:
  - out_valid=0 and busy=0 before the next edge.
  - After release, the next word with chan_en=8'hFF targets channel 0.
- DISPATCH8_STATS_EN defined:
  - 300 transfers → dispatched=300.
  - 65536 transfers from reset → dispatched=0.
